// File: rtl/load_store_unit_if.sv
// Bundle of the pipeline request/response signals and the data-memory bus
// seen by the load/store unit.
//
// Handshake: the requester raises req_valid with all req_* fields stable
// and holds them until it observes busy low at a clock edge with req_valid
// high; that edge accepts the request. busy plays the role of an inverted
// ready and stays high from the cycle after acceptance through the
// resp_valid cycle. resp_valid is a single-cycle pulse with no back-pressure.
// mem_MemRead / mem_MemWrite are single-cycle strobes and the memory answers
// mem_Read_data combinationally in the same cycle.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        busy;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        misaligned;
    logic [31:0] mem_Address;
    logic [31:0] mem_Write_data;
    logic        mem_MemRead;
    logic        mem_MemWrite;
    logic [31:0] mem_Read_data;

    // Load/store unit side
    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        input  mem_Read_data,
        output busy, resp_valid, resp_rdata, misaligned,
        output mem_Address, mem_Write_data, mem_MemRead, mem_MemWrite
    );

    // Pipeline plus data-memory side
    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        output mem_Read_data,
        input  busy, resp_valid, resp_rdata, misaligned,
        input  mem_Address, mem_Write_data, mem_MemRead, mem_MemWrite
    );
endinterface

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: turns byte-addressed byte/halfword/word
// requests into word accesses on a combinational-read data memory,
// merging sub-word stores by read-modify-write and extending load data.
module load_store_unit #(
    parameter int MEM_SIZE_BIT = 8
) (
    input  logic             clk,
    input  logic             reset,
    load_store_unit_if.slave bus,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    state_t                  state;
    logic                    r_write;
    logic [1:0]              r_size;
    logic                    r_unsigned;
    logic [1:0]              r_offset;
    logic [MEM_SIZE_BIT-1:0] r_index;
    logic [31:0]             r_wdata;
    logic [31:0]             read_word;

    logic                    rd_q;
    logic                    wr_q;
    logic                    resp_valid_q;
    logic                    misaligned_q;
    logic [31:0]             resp_rdata_q;
    logic [31:0]             addr_q;

    logic                    req_misaligned;
    logic [MEM_SIZE_BIT-1:0] req_index;
    logic [31:0]             merged_word;
    logic [31:0]             load_data;
    logic [7:0]              lane_byte;
    logic [15:0]             lane_half;

    // Address bits above the memory size are deliberately dropped (wrap).
    wire unused_addr_bits = &{1'b0, bus.req_addr[31:MEM_SIZE_BIT+2]};

    assign req_index = bus.req_addr[MEM_SIZE_BIT+1:2];

    // Alignment check on the live request, used only at acceptance.
    always_comb begin
        req_misaligned = 1'b0;
        case (bus.req_size)
            SIZE_BYTE: req_misaligned = 1'b0;
            SIZE_HALF: req_misaligned = bus.req_addr[0];
            SIZE_WORD: req_misaligned = (bus.req_addr[1:0] != 2'b00);
            default:   req_misaligned = 1'b1;
        endcase
    end

    // Word to write: the read word with the addressed lane replaced, or the
    // full store data for a word store.
    always_comb begin
        merged_word = read_word;
        case (r_size)
            SIZE_BYTE: merged_word[{r_offset, 3'b000} +: 8]     = r_wdata[7:0];
            SIZE_HALF: merged_word[{r_offset[1], 4'b0000} +: 16] = r_wdata[15:0];
            default:   merged_word = r_wdata;
        endcase
    end

    // Lane selection and sign/zero extension of the live memory word.
    always_comb begin
        lane_byte = bus.mem_Read_data[{r_offset, 3'b000} +: 8];
        lane_half = bus.mem_Read_data[{r_offset[1], 4'b0000} +: 16];
        case (r_size)
            SIZE_BYTE: load_data = {{24{~r_unsigned & lane_byte[7]}}, lane_byte};
            SIZE_HALF: load_data = {{16{~r_unsigned & lane_half[15]}}, lane_half};
            default:   load_data = bus.mem_Read_data;
        endcase
    end

    // Request FSM; all response and memory-strobe outputs are registered here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            r_write      <= 1'b0;
            r_size       <= 2'b00;
            r_unsigned   <= 1'b0;
            r_offset     <= 2'b00;
            r_index      <= '0;
            r_wdata      <= '0;
            read_word    <= '0;
            rd_q         <= 1'b0;
            wr_q         <= 1'b0;
            resp_valid_q <= 1'b0;
            misaligned_q <= 1'b0;
            resp_rdata_q <= '0;
            addr_q       <= '0;
        end else begin
            rd_q         <= 1'b0;
            wr_q         <= 1'b0;
            resp_valid_q <= 1'b0;
            misaligned_q <= 1'b0;
            resp_rdata_q <= '0;
            addr_q       <= '0;
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        r_write    <= bus.req_write;
                        r_size     <= bus.req_size;
                        r_unsigned <= bus.req_unsigned;
                        r_offset   <= bus.req_addr[1:0];
                        r_index    <= req_index;
                        r_wdata    <= bus.req_wdata;
                        if (req_misaligned) begin
                            state        <= RESP;
                            resp_valid_q <= 1'b1;
                            misaligned_q <= 1'b1;
                        end else if (bus.req_write && bus.req_size == SIZE_WORD) begin
                            state  <= WRITE;
                            wr_q   <= 1'b1;
                            addr_q <= 32'(req_index);
                        end else begin
                            state  <= READ;
                            rd_q   <= 1'b1;
                            addr_q <= 32'(req_index);
                        end
                    end
                end
                READ: begin
                    read_word <= bus.mem_Read_data;
                    if (r_write) begin
                        state  <= WRITE;
                        wr_q   <= 1'b1;
                        addr_q <= 32'(r_index);
                    end else begin
                        state        <= RESP;
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= load_data;
                    end
                end
                WRITE: begin
                    state        <= RESP;
                    resp_valid_q <= 1'b1;
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy           = (state != IDLE);
    assign bus.resp_valid     = resp_valid_q;
    assign bus.resp_rdata     = resp_rdata_q;
    assign bus.misaligned     = misaligned_q;
    assign bus.mem_Address    = addr_q;
    // Strobes are gated by reset so a reset during WRITE never commits.
    assign bus.mem_MemRead    = rd_q & ~reset;
    assign bus.mem_MemWrite   = wr_q & ~reset;
    assign bus.mem_Write_data = wr_q ? merged_word : 32'h0;
    assign dbg_state          = state;

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator side of the data-memory interface. Sits in the MEM stage between the pipeline and the word-addressed, combinational-read `DataMemory`. Accepts byte-addressed load and store requests of byte, halfword or word size. Translates them into `MemRead`/`MemWrite` word accesses, performs read-modify-write for sub-word stores, sign- or zero-extends load data, and rejects misaligned accesses.

## Interface
- `MEM_SIZE_BIT`, default 8: word-index width. The memory holds 2^MEM_SIZE_BIT words.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: request strobe; sampled only in IDLE.
- `req_write` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 halfword, 10 word, 11 reserved.
- `req_unsigned` in 1: loads only; 1 = zero-extend, 0 = sign-extend.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-justified.
- `busy` out 1: high whenever state ≠ IDLE; pipeline stall.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_rdata` out 32: extended load data; 0 for stores and errors.
- `misaligned` out 1: valid with `resp_valid`; 1 = request rejected.
- `mem_Address` out 32: word index `{0, req_addr[MEM_SIZE_BIT+1:2]}`.
- `mem_Write_data` out 32: word written to memory.
- `mem_MemRead` out 1: read strobe.
- `mem_MemWrite` out 1: write strobe.
- `mem_Read_data` in 32: combinational read data from memory.

## Operation
- Byte lanes are little-endian: byte offset k occupies bits [8k+7:8k].
- Address bits above `MEM_SIZE_BIT+1` are ignored, so addresses wrap modulo memory size.
- A request is misaligned if any of the following holds; it makes no memory access:
  - halfword with `addr[0]` = 1
  - word with `addr[1:0]` ≠ 0
  - `req_size` = 11
- In IDLE with `req_valid` = 1, latch all request fields, then branch:
  - misaligned → RESP
  - word store → WRITE
  - any other request → READ
- READ: drive `mem_MemRead` = 1 with the word index, and register `mem_Read_data`.
  - Load → RESP.
  - Sub-word store → WRITE, with the merged word: read word, with the addressed byte or halfword replaced by `req_wdata[7:0]` or `req_wdata[15:0]`.
- WRITE: drive `mem_MemWrite` = 1, with `mem_Write_data` = merged word (sub-word store) or `req_wdata` (word store) → RESP.
- RESP: `resp_valid` = 1, with `resp_rdata` and `misaligned` valid → IDLE.
- Load extraction:
  - Select the byte at `addr[1:0]` or the halfword at `addr[1]`.
  - Extend per `req_unsigned`; bit 7 or bit 15 is the sign bit.
- `req_valid` while `busy` is ignored, and the request is not queued. The requester holds the request until it sees `busy` low.
- Memory-side outputs are 0 in IDLE and RESP. `mem_Address` is valid only during READ and WRITE.

## Timing
- Request accepted in cycle N (IDLE, `req_valid` = 1).
- Load: READ in N+1, `resp_valid` in N+2.
- Word store: WRITE in N+1, `resp_valid` in N+2.
- Sub-word store: READ in N+1, WRITE in N+2, `resp_valid` in N+3.
- Misaligned: `resp_valid` with `misaligned` = 1 in N+1; `mem_MemRead` and `mem_MemWrite` are never asserted.
- `busy` is high from N+1 through the RESP cycle inclusive. A new request can be accepted in the cycle after RESP.
- Reset values: state IDLE. `busy`, `resp_valid`, `resp_rdata`, `misaligned`, `mem_Address`, `mem_Write_data`, `mem_MemRead` and `mem_MemWrite` are all 0.
- Reset mid-operation:
  - `mem_MemRead` and `mem_MemWrite` are forced to 0 in any cycle where `reset` = 1. A reset sampled during WRITE therefore suppresses that write.
  - The in-flight request is dropped and no `resp_valid` is issued.
- Back-to-back operations see memory updates immediately: a load accepted the cycle after a store's RESP reads the new data.

## Test plan
- **Word store and load:**
  - After reset, store word 0xDEADBEEF to 0x10 → `mem_MemWrite` high for one cycle at N+1 with `mem_Address` = 4; `resp_valid` at N+2.
  - Load word from 0x10 → `mem_MemRead` high at N+1; `resp_rdata` = 0xDEADBEEF with `resp_valid` at N+2.
- **Byte store:**
  - Store byte 0x80 to 0x11 → READ at N+1, WRITE at N+2 with `mem_Write_data` = 0xDEAD80EF, `resp_valid` at N+3.
  - Signed byte load from 0x11 → 0xFFFFFF80; unsigned byte load → 0x00000080.
- **Halfword store:**
  - Store halfword 0x8000 to 0x12 → word becomes 0x800080EF.
  - Signed halfword load from 0x12 → 0xFFFF8000; unsigned → 0x00008000.
- **Misalignment:** word load from 0x13, and halfword store to 0x11 → `resp_valid` and `misaligned` = 1 at N+1, `resp_rdata` = 0, no memory strobe, memory contents unchanged.
- **Busy and reset:**
  - Pulse `req_valid` with a different address while `busy` → ignored; only the original access occurs.
  - Assert `reset` during WRITE of a byte store → no `mem_MemWrite`, word unchanged, no `resp_valid`, all outputs 0 the next cycle.
- **Wrap-around:** with `MEM_SIZE_BIT` = 8, store word to 0x400 → `mem_Address` = 0; a word load from 0x0 returns the stored value.
